// File: rtl/nram_fifo_ctrl.sv
// Sequencer that runs an NRAMMUX 4x8 register file as a 3-entry FIFO with
// valid/ready push and pop ports; the write address always parks on the free slot.
module nram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  input  logic             io_flush,
  output logic [1:0]       io_count,
  output logic [WIDTH-1:0] io_ramD,
  output logic [AW-1:0]    io_ramWADD,
  output logic [AW-1:0]    io_ramRADD,
  input  logic [WIDTH-1:0] io_ramQ
);

  localparam logic [1:0] CNT_FULL = 2'd3;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [1:0]    count_q, count_d;
  logic          push, pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Flush blocks both handshakes, so the same term gates ready and valid.
  always_comb begin
    io_in_ready  = !io_flush && (count_q != CNT_FULL);
    io_out_valid = !io_flush && (count_q != 2'd0);
    push         = io_in_valid && io_in_ready;
    pop          = io_out_valid && io_out_ready;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (io_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // The register file writes every cycle; pointing it at wptr keeps idle writes harmless.
  always_comb begin
    io_ramD     = io_in_bits;
    io_ramWADD  = wptr_q;
    io_ramRADD  = rptr_q;
    io_out_bits = io_ramQ;
    io_count    = count_q;
  end

endmodule

// File: tb/tb_nram_fifo_ctrl.sv
// Directed bench for nram_fifo_ctrl with a behavioural NRAMMUX register file.
module tb_nram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_in_valid, io_in_ready;
  logic [7:0] io_in_bits;
  logic       io_out_valid, io_out_ready;
  logic [7:0] io_out_bits;
  logic       io_flush;
  logic [1:0] io_count;
  logic [7:0] io_ramD;
  logic [1:0] io_ramWADD, io_ramRADD;
  logic [7:0] io_ramQ;

  logic [7:0] mem [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Register file: unconditional write every edge, combinational read.
  always @(posedge clk) mem[io_ramWADD] <= io_ramD;
  assign io_ramQ = mem[io_ramRADD];

  nram_fifo_ctrl #(.WIDTH(8), .AW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_flush     (io_flush),
    .io_count     (io_count),
    .io_ramD      (io_ramD),
    .io_ramWADD   (io_ramWADD),
    .io_ramRADD   (io_ramRADD),
    .io_ramQ      (io_ramQ)
  );

  typedef struct {
    logic       iv;
    logic [7:0] bits;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [1:0] e_cnt;
    logic [1:0] e_w;
    logic [1:0] e_r;
    logic [7:0] e_q;
  } vec_t;

  vec_t tbl [36];

  function automatic vec_t mk(logic iv, logic [7:0] bits, logic ordy, logic fl,
                              logic ir, logic ov, logic [1:0] cnt, logic [1:0] w,
                              logic [1:0] r, logic [7:0] q);
    vec_t v;
    v.iv = iv; v.bits = bits; v.ordy = ordy; v.fl = fl;
    v.e_ir = ir; v.e_ov = ov; v.e_cnt = cnt; v.e_w = w; v.e_r = r; v.e_q = q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] bits, input logic ordy, input logic fl);
    io_in_valid  = iv;
    io_in_bits   = bits;
    io_out_ready = ordy;
    io_flush     = fl;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, hold full, drain; continuous stream; flush; post-flush push.
    tbl[0] = mk(1, 8'hA1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    tbl[1] = mk(1, 8'hB2, 0, 0, 1, 1, 1, 1, 0, 8'hA1);
    tbl[2] = mk(1, 8'hC3, 0, 0, 1, 1, 2, 2, 0, 8'hA1);
    for (int i = 3; i < 8; i++) tbl[i] = mk(1, 8'hFF, 0, 0, 0, 1, 3, 3, 0, 8'hA1);
    tbl[8]  = mk(0, 8'h00, 1, 0, 0, 1, 3, 3, 0, 8'hA1);
    tbl[9]  = mk(0, 8'h00, 1, 0, 1, 1, 2, 3, 1, 8'hB2);
    tbl[10] = mk(0, 8'h00, 1, 0, 1, 1, 1, 3, 2, 8'hC3);
    tbl[11] = mk(0, 8'h00, 0, 0, 1, 0, 0, 3, 3, 8'h00);
    tbl[12] = mk(1, 8'h00, 0, 0, 1, 0, 0, 3, 3, 8'h00);
    for (int j = 0; j < 15; j++)
      tbl[13+j] = mk(1, 8'(j+1), 1, 0, 1, 1, 1, 2'(j), 2'(3+j), 8'(j));
    tbl[28] = mk(0, 8'h00, 1, 0, 1, 1, 1, 3, 2, 8'h0F);
    tbl[29] = mk(1, 8'h11, 0, 0, 1, 0, 0, 3, 3, 8'h00);
    tbl[30] = mk(1, 8'h22, 0, 0, 1, 1, 1, 0, 3, 8'h11);
    tbl[31] = mk(1, 8'h33, 1, 1, 0, 0, 2, 1, 3, 8'h00);
    tbl[32] = mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    tbl[33] = mk(1, 8'h44, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    tbl[34] = mk(0, 8'h00, 1, 0, 1, 1, 1, 1, 0, 8'h44);
    tbl[35] = mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 8'h00);

    // Reset state while reset is held low.
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    #2;
    chk("rst_count", io_count, 2'd0);
    chk("rst_wadd", io_ramWADD, 2'd0);
    chk("rst_radd", io_ramRADD, 2'd0);
    chk("rst_out_valid", io_out_valid, 1'b0);
    chk("rst_in_ready", io_in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_hold_count", io_count, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 36; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].iv, tbl[i].bits, tbl[i].ordy, tbl[i].fl);
      #3;
      chk($sformatf("v%0d_in_ready", i), io_in_ready, tbl[i].e_ir);
      chk($sformatf("v%0d_out_valid", i), io_out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_count", i), io_count, tbl[i].e_cnt);
      chk($sformatf("v%0d_wadd", i), io_ramWADD, tbl[i].e_w);
      chk($sformatf("v%0d_radd", i), io_ramRADD, tbl[i].e_r);
      chk($sformatf("v%0d_ramD", i), io_ramD, tbl[i].bits);
      if (tbl[i].e_ov) chk($sformatf("v%0d_out_bits", i), io_out_bits, tbl[i].e_q);
      if (i == 7) begin
        chk("slot0", mem[0], 8'hA1);
        chk("slot1", mem[1], 8'hB2);
        chk("slot2", mem[2], 8'hC3);
      end
    end

    // Push 0x5A, then pull reset low between edges.
    @(posedge clk);
    #1;
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_rst_count", io_count, 2'd1);
    chk("pre_rst_valid", io_out_valid, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_count", io_count, 2'd0);
    chk("async_rst_valid", io_out_valid, 1'b0);
    chk("async_rst_wadd", io_ramWADD, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk("post_rst_valid", io_out_valid, 1'b1);
    chk("post_rst_bits", io_out_bits, 8'h3C);
    chk("post_rst_count", io_count, 2'd1);

    // Empty FIFO with out_ready high and no producer.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 8'(8'h70 + k), 1'b1, 1'b0);
      #3;
      chk($sformatf("idle%0d_out_valid", k), io_out_valid, 1'b0);
      chk($sformatf("idle%0d_radd", k), io_ramRADD, 2'd0);
      chk($sformatf("idle%0d_wadd", k), io_ramWADD, 2'd0);
      chk($sformatf("idle%0d_count", k), io_count, 2'd0);
    end
    @(posedge clk);
    #1;
    chk("idle_slot0", mem[0], 8'h73);
    chk("idle_radd_end", io_ramRADD, 2'd0);
    chk("idle_count_end", io_count, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nram_fifo_ctrl.md
# nram_fifo_ctrl

Sequencer that drives the `NRAMMUX` 4×8 register file as a 3-entry FIFO, with a valid/ready push port and a valid/ready pop port. The register file writes `io_D` into slot `io_WADD` on every clock edge and has no write enable. This block therefore always points `io_WADD` at the single free "write slot". Only an accepted push advances past that slot, so idle cycles overwrite free storage only. It sits between a streaming producer/consumer pair and one `NRAMMUX` instance, sharing its clock.

## Interface
- `WIDTH`, 8: data width; equals the register file word width.
- `AW`, 2: address width. Storage depth is 2^AW = 4; usable capacity is 2^AW−1 = 3.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low. Low clears all state immediately; release is synchronous to `clk`.
- `io_in_valid`  in  1: producer has a word.
- `io_in_ready`  out  1: block accepts a word this cycle.
- `io_in_bits`  in  WIDTH: producer data.
- `io_out_valid`  out  1: head word available.
- `io_out_ready`  in  1: consumer takes the head word.
- `io_out_bits`  out  WIDTH: head word, equal to `io_ramQ`.
- `io_flush`  in  1: synchronous clear of the FIFO.
- `io_count`  out  2: number of stored words, 0..3.
- `io_ramD`  out  WIDTH: to `NRAMMUX.io_D`; always equals `io_in_bits`.
- `io_ramWADD`  out  AW: to `NRAMMUX.io_WADD`; equals `wptr`.
- `io_ramRADD`  out  AW: to `NRAMMUX.io_RADD`; equals `rptr`.
- `io_ramQ`  in  WIDTH: from `NRAMMUX.io_Q`.

## Operation
- State registers:
  - `wptr[AW-1:0]`: next write slot.
  - `rptr[AW-1:0]`: head slot.
  - `count[1:0]`: stored words.
- Invariants:
  - count = (wptr − rptr) mod 4, and count ≤ 3.
  - Slot `wptr` never holds valid data.
- `io_in_ready` = !io_flush && count != 3.
- `io_out_valid` = !io_flush && count != 0.
- push = io_in_valid && io_in_ready.
- pop = io_out_valid && io_out_ready.
- Push: the register file captures `io_in_bits` into slot `wptr` at the edge; `wptr` increments mod 4.
- Pop: `rptr` increments mod 4.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Non-push cycles still write `io_in_bits` into slot `wptr`. This is harmless because the slot is free, and it is required behaviour, not an error.
- Flush: at the next edge `wptr`, `rptr` and `count` all become 0. Both handshakes are blocked in the flush cycle, so no push or pop occurs.
- Pointer wrap: 3 → 0 on both pointers; no other special case.
- No bypass: a word pushed at edge N is visible on `io_out_bits` no earlier than cycle N+1.
- The `NRAMMUX` synchronous active-high reset is generated outside this block. Register-file contents are don't-care after reset because count = 0.

## Timing
- Reset (reset low), all state and outputs:
  - wptr = rptr = 0, count = 0.
  - `io_ramWADD` = `io_ramRADD` = 0, `io_count` = 0, `io_out_valid` = 0.
  - `io_in_ready` reads 1, but no handshake is recorded while reset is low.
- Reset asserted mid-operation: all stored words are discarded immediately. The first handshake can be accepted in the first cycle after release.
- All outputs are combinational from state plus `io_flush`; there are no registered outputs.
- `io_in_ready` does not depend on `io_out_ready`: when full, a same-cycle pop does not admit a push.
- Latency from push to `io_out_valid`: 1 cycle when empty.
- Throughput: one push and one pop per cycle when 0 < count < 3.
- `io_out_bits` is stable while `io_out_valid`=1 and `io_out_ready`=0.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3 on consecutive cycles with out_ready=0:
  - `io_count` steps 1, 2, 3.
  - `io_in_ready`=0 at count 3.
  - `io_ramWADD` sequence is 0, 1, 2, 3.
  - Slots 0–2 hold A1, B2, C3.
- From full, drive in_valid=1 with in_bits 0xFF for 5 cycles, then pop 3:
  - Outputs are A1, B2, C3 in order.
  - 0xFF never appears; count ends at 0 and out_valid=0.
- Continuous push and pop of 0x00..0x0F from count=1:
  - Output order is preserved and count stays at 1.
  - Both pointers wrap 3 → 0 at least 4 times.
- With count=2, assert `io_flush` while in_valid=out_ready=1:
  - in_ready=0 and out_valid=0 in the flush cycle.
  - Next cycle count=0 and wptr=rptr=0.
  - The pushed word is absent from later output.
- Push 0x5A, then pull reset low mid-cycle:
  - count=0 and out_valid=0 immediately, without a clock edge.
  - After release, push 0x3C: out_bits=0x3C one cycle later.
- Empty FIFO with out_ready=1 and in_valid=0 for 4 cycles:
  - No pop occurs and rptr stays 0.
  - Idle writes hit slot 0 only, and count stays 0.
